// File: rtl/bt_msg_scheduler.sv
// Bluetooth message scheduler: round-robin arbitration between fault, node
// and status event sources, serialising each accepted request as a 5-byte
// ASCII frame (tag0, tag1, '-', payload, '#') into a start/busy UART engine.
module bt_msg_scheduler #(
    parameter int unsigned BYTE_GAP = 500
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [7:0] payload0,
    input  logic [7:0] payload1,
    input  logic [7:0] payload2,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam logic [15:0] GAP_LAST = (BYTE_GAP == 0) ? 16'd0 : 16'(BYTE_GAP - 1);
    localparam logic        GAP_EN   = (BYTE_GAP != 0);

    typedef enum logic [2:0] {IDLE, SEND, HOLD, WAIT, GAP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  src, src_nxt;
    logic [7:0]  payload_q, payload_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [15:0] gap_cnt, gap_nxt;
    logic [1:0]  rr_ptr, rr_nxt;
    logic [2:0]  gnt_nxt, done_nxt;
    logic        tx_start_nxt;
    logic [7:0]  tx_data_nxt, frames_nxt;

    logic [3:0]  req_ext;
    logic [1:0]  cand, win;
    logic        win_valid;
    logic [15:0] tag;
    logic [7:0]  frame_byte;

    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    function automatic logic [15:0] src_tag(input logic [1:0] s);
        case (s)
            2'd0:    return 16'h4649;   // "FI"
            2'd1:    return 16'h4E44;   // "ND"
            default: return 16'h5354;   // "ST"
        endcase
    endfunction

    assign busy    = (state != IDLE);
    assign req_ext = {1'b0, req};

    // Round-robin search starting at rr_ptr, wrapping modulo 3.
    always_comb begin
        win_valid = 1'b0;
        win       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = mod3_add(rr_ptr, 2'(k));
            if (!win_valid && req_ext[cand]) begin
                win_valid = 1'b1;
                win       = cand;
            end
        end
    end

    // Byte of the latched frame selected by idx.
    always_comb begin
        tag        = src_tag(src);
        frame_byte = 8'h23;
        case (idx)
            3'd0:    frame_byte = tag[15:8];
            3'd1:    frame_byte = tag[7:0];
            3'd2:    frame_byte = 8'h2D;
            3'd3:    frame_byte = payload_q;
            default: frame_byte = 8'h23;
        endcase
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt    = state;
        src_nxt      = src;
        payload_nxt  = payload_q;
        idx_nxt      = idx;
        gap_nxt      = gap_cnt;
        rr_nxt       = rr_ptr;
        gnt_nxt      = '0;
        done_nxt     = '0;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        frames_nxt   = frames_sent;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    gnt_nxt   = 3'b001 << win;
                    src_nxt   = win;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                    case (win)
                        2'd0:    payload_nxt = payload0;
                        2'd1:    payload_nxt = payload1;
                        default: payload_nxt = payload2;
                    endcase
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = frame_byte;
                    state_nxt    = HOLD;
                end
            end
            HOLD: state_nxt = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    if (idx == 3'd4) begin
                        done_nxt   = 3'b001 << src;
                        frames_nxt = frames_sent + 8'd1;
                        rr_nxt     = mod3_add(src, 2'd1);
                        state_nxt  = IDLE;
                    end else if (!GAP_EN) begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = SEND;
                    end else begin
                        gap_nxt   = '0;
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                gap_nxt = gap_cnt + 16'd1;
                if (gap_cnt == GAP_LAST) begin
                    idx_nxt   = idx + 3'd1;
                    state_nxt = SEND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state       <= IDLE;
            src         <= '0;
            payload_q   <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            rr_ptr      <= '0;
            gnt         <= '0;
            done        <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            frames_sent <= '0;
        end else begin
            state       <= state_nxt;
            src         <= src_nxt;
            payload_q   <= payload_nxt;
            idx         <= idx_nxt;
            gap_cnt     <= gap_nxt;
            rr_ptr      <= rr_nxt;
            gnt         <= gnt_nxt;
            done        <= done_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            frames_sent <= frames_nxt;
        end
    end

endmodule

// File: tb/tb_bt_msg_scheduler.sv
// Directed self-checking bench for bt_msg_scheduler: one instance with no
// inter-byte gap (dut_a) and one with BYTE_GAP=3 (dut_b), each driving a
// UART model that stays busy 4 cycles after every tx_start.
module tb_bt_msg_scheduler;

    logic       clk_50M = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = '0;
    logic [7:0] payload0 = '0, payload1 = '0, payload2 = '0;
    logic [2:0] gnt_a, done_a;
    logic [7:0] tx_data_a, frames_a;
    logic       tx_start_a, tx_busy_a, busy_a;
    logic       hold_busy_a = 1'b0;
    int         cnt_a = 0;

    logic [2:0] req_b = '0;
    logic [7:0] payload1_b = '0;
    logic [7:0] zero_b = '0;
    logic [2:0] gnt_b, done_b;
    logic [7:0] tx_data_b, frames_b;
    logic       tx_start_b, tx_busy_b, busy_b;
    int         cnt_b = 0;

    int errors = 0;
    int checks = 0;

    logic [7:0] txq[$];
    logic [2:0] gntq[$];

    always #5 clk_50M = ~clk_50M;

    bt_msg_scheduler #(.BYTE_GAP(0)) dut_a (
        .clk_50M(clk_50M), .reset(reset), .req(req),
        .payload0(payload0), .payload1(payload1), .payload2(payload2),
        .gnt(gnt_a), .done(done_a), .tx_data(tx_data_a), .tx_start(tx_start_a),
        .tx_busy(tx_busy_a), .busy(busy_a), .frames_sent(frames_a)
    );

    bt_msg_scheduler #(.BYTE_GAP(3)) dut_b (
        .clk_50M(clk_50M), .reset(reset), .req(req_b),
        .payload0(zero_b), .payload1(payload1_b), .payload2(zero_b),
        .gnt(gnt_b), .done(done_b), .tx_data(tx_data_b), .tx_start(tx_start_b),
        .tx_busy(tx_busy_b), .busy(busy_b), .frames_sent(frames_b)
    );

    // UART models: busy for 4 cycles starting the cycle after tx_start.
    always @(posedge clk_50M) begin
        if (tx_start_a === 1'b1) cnt_a <= 4;
        else if (cnt_a != 0)     cnt_a <= cnt_a - 1;
        if (tx_start_b === 1'b1) cnt_b <= 4;
        else if (cnt_b != 0)     cnt_b <= cnt_b - 1;
    end
    assign tx_busy_a = (cnt_a != 0) || hold_busy_a;
    assign tx_busy_b = (cnt_b != 0);

    // Record bytes sent and grants issued by dut_a, sampled mid-cycle.
    always @(negedge clk_50M) begin
        if (tx_start_a === 1'b1) txq.push_back(tx_data_a);
        if (gnt_a !== 3'b000 && !$isunknown(gnt_a)) gntq.push_back(gnt_a);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        req_b = '0;
        hold_busy_a = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        txq.delete();
        gntq.delete();
    endtask

    task automatic wait_done_a(input int maxc, output logic [2:0] d, output bit ok);
        ok = 1'b0;
        d = '0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (done_a !== 3'b000) begin
                d = done_a;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt_a !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt_a); end
        checks++; if (done_a !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", done_a); end
        checks++; if (tx_start_a !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start_a); end
        checks++; if (tx_data_a !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (frames_a !== 8'd0) begin errors++; $display("FAIL reset_frames: got %0d expected 0", frames_a); end
    endtask

    task automatic test_single_fault();
        logic [7:0] exp [5];
        logic [2:0] d;
        bit ok;
        exp[0] = 8'h46; exp[1] = 8'h49; exp[2] = 8'h2D; exp[3] = 8'h31; exp[4] = 8'h23;
        do_reset();
        payload0 = 8'h31;
        req = 3'b001;
        tick();
        checks++; if (gnt_a !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b expected 001", gnt_a); end
        checks++; if (tx_start_a !== 1'b0) begin errors++; $display("FAIL single_gnt_no_start: got %b expected 0", tx_start_a); end
        req = '0;
        tick();
        checks++; if (tx_start_a !== 1'b1 || tx_data_a !== 8'h46) begin
            errors++; $display("FAIL single_first_start: got start=%b data=%h expected start=1 data=46", tx_start_a, tx_data_a);
        end
        wait_done_a(200, d, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout: got no done expected done within 200 cycles"); end
        checks++; if (d !== 3'b001) begin errors++; $display("FAIL single_done: got %b expected 001", d); end
        checks++; if (frames_a !== 8'd1) begin errors++; $display("FAIL single_frames: got %0d expected 1", frames_a); end
        checks++; if (txq.size() != 5) begin errors++; $display("FAIL single_nbytes: got %0d expected 5", txq.size()); end
        for (int i = 0; i < 5 && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp[i]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, txq[i], exp[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp [4];
        logic [2:0] d;
        bit ok;
        int ndone;
        exp[0] = 3'b001; exp[1] = 3'b010; exp[2] = 3'b100; exp[3] = 3'b001;
        do_reset();
        payload0 = 8'h30; payload1 = 8'h31; payload2 = 8'h32;
        req = 3'b111;
        ndone = 0;
        for (int n = 0; n < 4; n++) begin
            wait_done_a(200, d, ok);
            if (!ok) break;
            ndone++;
        end
        checks++; if (ndone != 4) begin errors++; $display("FAIL rr_done_count: got %0d expected 4", ndone); end
        checks++; if (frames_a !== 8'd4) begin errors++; $display("FAIL rr_frames: got %0d expected 4", frames_a); end
        checks++; if (gntq.size() != 4) begin errors++; $display("FAIL rr_ngrants: got %0d expected 4", gntq.size()); end
        for (int i = 0; i < 4 && i < gntq.size(); i++) begin
            checks++; if (gntq[i] !== exp[i]) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, gntq[i], exp[i]); end
        end
        req = '0;
    endtask

    task automatic test_gap();
        logic [7:0] exp [5];
        logic [7:0] got [5];
        int cyc, t_low, nstart, extra;
        logic prev_busy;
        bit seen_done;
        exp[0] = 8'h4E; exp[1] = 8'h44; exp[2] = 8'h2D; exp[3] = 8'h4B; exp[4] = 8'h23;
        for (int i = 0; i < 5; i++) got[i] = '0;
        do_reset();
        payload1_b = 8'h4B;
        req_b = 3'b010;
        cyc = 0; t_low = 0; nstart = 0; extra = 0;
        prev_busy = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            cyc++;
            if (i == 0) req_b = '0;
            if (prev_busy && !tx_busy_b) t_low = cyc;
            prev_busy = tx_busy_b;
            if (tx_start_b === 1'b1) begin
                if (nstart < 5) got[nstart] = tx_data_b;
                if (nstart > 0) begin
                    // busy-low cycle, then 3 gap cycles, SEND, registered tx_start
                    checks++; if (cyc - t_low != 5) begin
                        errors++; $display("FAIL gap_byte%0d: got %0d cycles busy-low to start expected 5", nstart, cyc - t_low);
                    end
                end
                nstart++;
            end
            if (done_b !== 3'b000) begin seen_done = 1'b1; break; end
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL gap_done_timeout: got no done expected done within 300 cycles"); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_start_b === 1'b1) extra++;
        end
        checks++; if (nstart != 5) begin errors++; $display("FAIL gap_nstarts: got %0d expected 5", nstart); end
        checks++; if (extra != 0) begin errors++; $display("FAIL gap_after_last: got %0d starts expected 0", extra); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL gap_byte_data%0d: got %h expected %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_payload_change();
        logic [2:0] d;
        bit ok;
        do_reset();
        payload1 = 8'h35;
        req = 3'b010;
        tick();
        checks++; if (gnt_a !== 3'b010) begin errors++; $display("FAIL pchg_gnt: got %b expected 010", gnt_a); end
        req = '0;
        tick();
        payload1 = 8'h39;
        wait_done_a(200, d, ok);
        checks++; if (!ok || d !== 3'b010) begin errors++; $display("FAIL pchg_done: got %b expected 010", d); end
        checks++; if (txq.size() != 5) begin errors++; $display("FAIL pchg_nbytes: got %0d expected 5", txq.size()); end
        if (txq.size() > 3) begin
            checks++; if (txq[3] !== 8'h35) begin errors++; $display("FAIL pchg_payload: got %h expected 35", txq[3]); end
        end
    endtask

    task automatic test_busy_hold();
        int starts;
        do_reset();
        payload0 = 8'h33;
        hold_busy_a = 1'b1;
        req = 3'b001;
        tick();
        req = '0;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start_a === 1'b1) starts++;
        end
        checks++; if (starts != 0) begin errors++; $display("FAIL hold_no_start: got %0d starts expected 0", starts); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL hold_busy_out: got %b expected 1", busy_a); end
        hold_busy_a = 1'b0;
        starts = 0;
        tick();
        checks++; if (tx_start_a !== 1'b1) begin errors++; $display("FAIL hold_release: got %b expected 1", tx_start_a); end
        if (tx_start_a === 1'b1) starts++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tx_start_a === 1'b1) starts++;
        end
        checks++; if (starts != 1) begin errors++; $display("FAIL hold_one_pulse: got %0d starts expected 1", starts); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [5];
        logic [2:0] d;
        bit ok, found;
        int ndone;
        exp[0] = 8'h53; exp[1] = 8'h54; exp[2] = 8'h2D; exp[3] = 8'h55; exp[4] = 8'h23;
        do_reset();
        payload0 = 8'h41;
        req = 3'b001;
        tick();
        req = '0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_start_a === 1'b1 && tx_data_a === 8'h2D) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_reach_byte2: got no byte 2 expected byte 2 within 100 cycles"); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (gnt_a !== 3'b000 || done_a !== 3'b000) begin
            errors++; $display("FAIL mid_gnt_done: got gnt=%b done=%b expected 000/000", gnt_a, done_a);
        end
        checks++; if (tx_start_a !== 1'b0 || tx_data_a !== 8'h00) begin
            errors++; $display("FAIL mid_tx: got start=%b data=%h expected 0/00", tx_start_a, tx_data_a);
        end
        checks++; if (busy_a !== 1'b0 || frames_a !== 8'd0) begin
            errors++; $display("FAIL mid_busy_frames: got busy=%b frames=%0d expected 0/0", busy_a, frames_a);
        end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_a !== 3'b000) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL mid_no_done: got %0d done pulses expected 0", ndone); end
        txq.delete();
        payload2 = 8'h55;
        req = 3'b100;
        tick();
        req = '0;
        checks++; if (gnt_a !== 3'b100) begin errors++; $display("FAIL mid_regrant: got %b expected 100", gnt_a); end
        wait_done_a(200, d, ok);
        checks++; if (!ok || d !== 3'b100) begin errors++; $display("FAIL mid_redone: got %b expected 100", d); end
        checks++; if (frames_a !== 8'd1) begin errors++; $display("FAIL mid_frames: got %0d expected 1", frames_a); end
        checks++; if (txq.size() != 5) begin errors++; $display("FAIL mid_nbytes: got %0d expected 5", txq.size()); end
        for (int i = 0; i < 5 && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp[i]) begin errors++; $display("FAIL mid_byte%0d: got %h expected %h", i, txq[i], exp[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] d;
        bit ok;
        int ndone;
        logic [7:0] f255;
        do_reset();
        payload0 = 8'h57;
        req = 3'b001;
        ndone = 0;
        f255 = '0;
        for (int n = 1; n <= 256; n++) begin
            wait_done_a(200, d, ok);
            if (!ok) break;
            ndone++;
            if (n == 255) f255 = frames_a;
        end
        req = '0;
        checks++; if (ndone != 256) begin errors++; $display("FAIL wrap_count: got %0d frames expected 256", ndone); end
        checks++; if (f255 !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", f255); end
        checks++; if (frames_a !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", frames_a); end
    endtask

    initial begin
        test_reset();
        test_single_fault();
        test_round_robin();
        test_gap();
        test_payload_change();
        test_busy_hold();
        test_reset_midframe();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
